// File: rtl/riscv_pkg.sv
// Shared branch definitions: funct3 encodings, resolver state encoding and
// the flush down-counter width.
package riscv_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Wide enough for FLUSH_DEPTH-1 with FLUSH_DEPTH up to 4.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_e;

    function automatic logic is_aligned4(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// EX-stage branch bus: the EX side drives operands/condition flags, the
// resolver answers with redirect, flush, exception pulses and counters.
interface branch_resolve_if #(
    parameter int XLEN = 64
);
    logic            ex_valid_i;
    logic            ex_branch_i;
    logic [2:0]      ex_funct3_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_imm_i;
    logic            eq_i;
    logic [XLEN-1:0] slt_i;
    logic [XLEN-1:0] sltu_i;
    logic            stall_i;
    logic            redirect_valid_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic            flush_o;
    logic            misalign_o;
    logic            illegal_o;
    logic [31:0]     branch_cnt_o;
    logic [31:0]     taken_cnt_o;

    modport master (
        output ex_valid_i, ex_branch_i, ex_funct3_i, ex_pc_i, ex_imm_i,
               eq_i, slt_i, sltu_i, stall_i,
        input  redirect_valid_o, redirect_pc_o, flush_o, misalign_o,
               illegal_o, branch_cnt_o, taken_cnt_o
    );

    modport slave (
        input  ex_valid_i, ex_branch_i, ex_funct3_i, ex_pc_i, ex_imm_i,
               eq_i, slt_i, sltu_i, stall_i,
        output redirect_valid_o, redirect_pc_o, flush_o, misalign_o,
               illegal_o, branch_cnt_o, taken_cnt_o
    );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition: decodes funct3 against comparator flags
// into taken / illegal.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_eq,
    input  logic       i_slt,
    input  logic       i_sltu,
    output logic       o_taken,
    output logic       o_illegal
);

    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_taken = i_eq;
            F3_BNE:  o_taken = ~i_eq;
            F3_BLT:  o_taken = i_slt;
            F3_BGE:  o_taken = ~i_slt;
            F3_BLTU: o_taken = i_sltu;
            F3_BGEU: o_taken = ~i_sltu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution in EX: computes the target, issues a one-cycle redirect
// and a FLUSH_DEPTH-cycle flush for taken branches, and counts branches.
module branch_resolve
    import riscv_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int FLUSH_DEPTH = 2
) (
    input logic             clk,
    input logic             rst_n,
    branch_resolve_if.slave bus
);

    br_state_e        r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic             r_redirect_valid, w_redirect_valid_n;
    logic [XLEN-1:0]  r_redirect_pc, w_redirect_pc_n;
    logic             r_flush, w_flush_n;
    logic             r_misalign, w_misalign_n;
    logic             r_illegal, w_illegal_n;
    logic [31:0]      r_branch_cnt, w_branch_cnt_n;
    logic [31:0]      r_taken_cnt, w_taken_cnt_n;

    logic             w_taken;
    logic             w_illegal;
    logic             w_accept;
    logic [XLEN-1:0]  w_target;
    logic             w_unused_cmp;

    branch_cond u_cond (
        .i_funct3  (bus.ex_funct3_i),
        .i_eq      (bus.eq_i),
        .i_slt     (bus.slt_i[0]),
        .i_sltu    (bus.sltu_i[0]),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    // Comparators deliver full-width results; only the LSB is meaningful.
    assign w_unused_cmp = ^{bus.slt_i[XLEN-1:1], bus.sltu_i[XLEN-1:1]};

    assign w_target = bus.ex_pc_i + bus.ex_imm_i;
    assign w_accept = bus.ex_valid_i & bus.ex_branch_i & (r_state == ST_IDLE);

    always_comb begin
        w_state_n          = r_state;
        w_cnt_n            = r_cnt;
        w_redirect_valid_n = 1'b0;
        w_redirect_pc_n    = r_redirect_pc;
        w_flush_n          = 1'b0;
        w_misalign_n       = 1'b0;
        w_illegal_n        = 1'b0;
        w_branch_cnt_n     = r_branch_cnt;
        w_taken_cnt_n      = r_taken_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_illegal_n = 1'b1;
                    end else begin
                        w_branch_cnt_n = r_branch_cnt + 32'd1;
                        if (w_taken) begin
                            w_taken_cnt_n = r_taken_cnt + 32'd1;
                            if (!is_aligned4(w_target[1:0])) begin
                                w_misalign_n = 1'b1;
                            end else begin
                                w_state_n          = ST_REDIRECT;
                                w_redirect_valid_n = 1'b1;
                                w_redirect_pc_n    = w_target;
                                w_flush_n          = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_REDIRECT: begin
                if (FLUSH_DEPTH > 1) begin
                    w_state_n = ST_FLUSH;
                    w_cnt_n   = CNT_W'(FLUSH_DEPTH - 1);
                    w_flush_n = 1'b1;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // r_cnt counts the flush cycles still owed, including this one.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_n = ST_IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n   = r_cnt - CNT_W'(1);
                    w_flush_n = 1'b1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // A stall is a global enable: every register, pending pulses included,
    // holds until the stall drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_misalign       <= 1'b0;
            r_illegal        <= 1'b0;
            r_branch_cnt     <= '0;
            r_taken_cnt      <= '0;
        end else if (!bus.stall_i) begin
            r_state          <= w_state_n;
            r_cnt            <= w_cnt_n;
            r_redirect_valid <= w_redirect_valid_n;
            r_redirect_pc    <= w_redirect_pc_n;
            r_flush          <= w_flush_n;
            r_misalign       <= w_misalign_n;
            r_illegal        <= w_illegal_n;
            r_branch_cnt     <= w_branch_cnt_n;
            r_taken_cnt      <= w_taken_cnt_n;
        end
    end

    assign bus.redirect_valid_o = r_redirect_valid;
    assign bus.redirect_pc_o    = r_redirect_pc;
    assign bus.flush_o          = r_flush;
    assign bus.misalign_o       = r_misalign;
    assign bus.illegal_o        = r_illegal;
    assign bus.branch_cnt_o     = r_branch_cnt;
    assign bus.taken_cnt_o      = r_taken_cnt;

endmodule
